// File: rtl/instr_encode_loader_if.sv
// Field-bundle handshake and imem write port of instr_encode_loader.
// master = bundle source / imem sink, slave = the loader itself.
interface instr_encode_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4:0]            in_opcode;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs;
   logic [4:0]            in_rt;
   logic [4:0]            in_shamt;
   logic [4:0]            in_aluop;
   logic [16:0]           in_imm;
   logic [26:0]           in_target;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_data;

   modport master (
      output in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
             in_imm, in_target,
      input  in_ready, imem_we, imem_addr, imem_data
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop,
             in_imm, in_target,
      output in_ready, imem_we, imem_addr, imem_data
   );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into 32-bit ISA words and streams them into imem.
// Optional macro ENC_CHECKSUM_EN: running XOR of the words written this session.
module instr_encode_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int BASE_ADDR  = 0,
   parameter int DEPTH      = 4096
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  finish,
   instr_encode_loader_if.slave  bus,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  full,
   output logic                  done,
   output logic                  illegal,
   output logic [31:0]           checksum,
   output logic [1:0]            state_dbg
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE_W  = ADDR_WIDTH'(BASE_ADDR);

   logic [1:0]            state;
   logic [1:0]            state_nx;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic                  accept;
   logic                  legal;
   logic                  write_ok;
   logic                  last_word;
   logic [31:0]           enc_word;

   // Handshake: a bundle transfers on a rising edge where in_valid & in_ready;
   // in_valid may be held indefinitely, in_ready never depends on in_valid.
   assign bus.in_ready = (state == S_LOAD) & ~start;
   assign accept       = bus.in_valid & bus.in_ready;
   assign write_ok     = accept & legal;
   assign last_word    = write_ok & ((wr_count + (ADDR_WIDTH+1)'(1)) == DEPTH_W);

   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (bus.in_opcode)
         5'b00000:
            enc_word = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt,
                        bus.in_shamt, bus.in_aluop, 2'b00};
         5'b00101, 5'b00010, 5'b00110, 5'b00111, 5'b01000:
            enc_word = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_imm};
         5'b00001, 5'b00011, 5'b10101, 5'b10110:
            enc_word = {bus.in_opcode, bus.in_target};
         5'b00100:
            enc_word = {bus.in_opcode, bus.in_rd, 22'd0};
         default:
            legal = 1'b0;
      endcase
   end

   // start wins over finish; finish in the same cycle as an accept still writes.
   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = S_LOAD;
      end else begin
         case (state)
            S_LOAD: begin
               if (finish)         state_nx = S_DONE;
               else if (last_word) state_nx = S_FULL;
            end
            S_FULL: if (finish) state_nx = S_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         bus.imem_we   <= 1'b0;
         bus.imem_addr <= BASE_W;
         bus.imem_data <= '0;
         wr_ptr        <= BASE_W;
         wr_count      <= '0;
         illegal       <= 1'b0;
      end else begin
         state       <= state_nx;
         bus.imem_we <= write_ok;
         if (start) begin
            wr_ptr   <= BASE_W;
            wr_count <= '0;
            illegal  <= 1'b0;
         end else begin
            if (write_ok) begin
               bus.imem_addr <= wr_ptr;
               bus.imem_data <= enc_word;
               wr_ptr        <= wr_ptr + ADDR_WIDTH'(1);
               wr_count      <= wr_count + (ADDR_WIDTH+1)'(1);
            end
            if (accept && !legal) illegal <= 1'b1;
         end
      end
   end

`ifdef ENC_CHECKSUM_EN
   logic [31:0] csum_q;

   // Folded in at the same edge that presents the word on imem_data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      csum_q <= '0;
      else if (start)    csum_q <= '0;
      else if (write_ok) csum_q <= csum_q ^ enc_word;
   end
   assign checksum = csum_q;
`else
   assign checksum = 32'h0;
`endif

   assign full      = (wr_count == DEPTH_W);
   assign done      = (state == S_DONE);
   assign state_dbg = state;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: directed scenarios then randomized sessions,
// checked against a field-level encoding/session model.
module tb_instr_encode_loader;
  localparam int AW    = 4;
  localparam int BASE  = 2;
  localparam int DEPTH = 4;
  localparam int W     = 32 + AW + 32 + 32;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          finish;
  logic [AW:0]   wr_count;
  logic          full;
  logic          done;
  logic          illegal;
  logic [31:0]   checksum;
  logic [1:0]    state_dbg;

  instr_encode_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .finish   (finish),
    .bus      (bus),
    .wr_count (wr_count),
    .full     (full),
    .done     (done),
    .illegal  (illegal),
    .checksum (checksum),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  int cyc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // session model
  bit          m_loading;
  bit          m_done;
  bit          m_illegal;
  int          m_count;
  logic [31:0] m_csum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_encode(input int unsigned op, rd, rs, rt, sh, alu, imm, tgt,
                                     output logic [31:0] w, output bit ok);
    ok = 1'b1;
    if (op == 0)                      w = (op << 27) | (rd << 22) | (rs << 17) | (rt << 12) | (sh << 7) | (alu << 2);
    else if (op inside {5, 2, 6, 7, 8}) w = (op << 27) | (rd << 22) | (rs << 17) | imm;
    else if (op inside {1, 3, 21, 22})  w = (op << 27) | tgt;
    else if (op == 4)                 w = (op << 27) | (rd << 22);
    else begin
      ok = 1'b0;
      w  = 32'h0;
    end
  endfunction

  function automatic logic [31:0] exp_csum();
`ifdef ENC_CHECKSUM_EN
    return m_csum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_illegal = 0; m_count = 0; m_csum = '0;
  endtask

  // driver: one clock cycle of stimulus, model update and status checks
  task automatic step(input bit v, input logic [4:0] op, rd, rs, rt, sh, alu,
                      input logic [16:0] imm, input logic [26:0] tgt,
                      input bit st, input bit fin);
    logic [31:0] word;
    bit ok;
    bit exp_rdy;
    bus.in_valid = v;  bus.in_opcode = op; bus.in_rd = rd; bus.in_rs = rs;
    bus.in_rt = rt;    bus.in_shamt = sh;  bus.in_aluop = alu;
    bus.in_imm = imm;  bus.in_target = tgt;
    start = st; finish = fin;
    @(negedge clock);
    exp_rdy = m_loading && !st;
    check("in_ready", bus.in_ready, exp_rdy);
    if (v && exp_rdy) begin
      ref_encode(op, rd, rs, rt, sh, alu, imm, tgt, word, ok);
      if (ok) begin
        m_csum ^= word;
        exp_q.push_back({32'(cyc + 1), AW'(BASE + m_count), word, exp_csum()});
        m_count++;
      end else begin
        m_illegal = 1;
      end
    end
    if (st) begin
      model_reset();
      m_loading = 1;
    end else if (fin && (m_loading || m_count == DEPTH)) begin
      m_loading = 0;
      m_done    = 1;
    end else if (m_loading && m_count == DEPTH) begin
      m_loading = 0;
    end
    @(posedge clock);
    #1;
    check("wr_count", wr_count, m_count);
    check("full", full, (m_count == DEPTH));
    check("done", done, m_done);
    check("illegal", illegal, m_illegal);
    bus.in_valid = 1'b0; start = 1'b0; finish = 1'b0;
  endtask

  task automatic offer(input logic [4:0] op, rd, rs, rt, input logic [16:0] imm, input logic [26:0] tgt);
    step(1'b1, op, rd, rs, rt, 5'd0, 5'd0, imm, tgt, 1'b0, 1'b0);
  endtask

  task automatic ctrl(input bit st, input bit fin);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, st, fin);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, bus.imem_we, 1'b0);
    check({tag, "_addr"}, bus.imem_addr, AW'(BASE));
    check({tag, "_data"}, bus.imem_data, 32'h0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_illegal"}, illegal, 1'b0);
    check({tag, "_checksum"}, checksum, 32'h0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
  endtask

  // monitor: pops one expectation per presented write
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (reset_n && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                 bus.imem_addr, bus.imem_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(e[W-1 -: 32]));
        check("write_addr", bus.imem_addr, e[64 +: AW]);
        check("write_data", bus.imem_data, e[32 +: 32]);
        check("checksum", checksum, e[31:0]);
      end
    end
  end

  initial begin
    int legal_ops[11] = '{0, 5, 2, 6, 7, 8, 1, 3, 21, 22, 4};
    logic [31:0] csum_2w;
    bit st, fin;
    logic [4:0] op;

    bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs = 0; bus.in_rt = 0;
    bus.in_shamt = 0; bus.in_aluop = 0; bus.in_imm = 0; bus.in_target = 0;
    start = 0; finish = 0;
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // R add, then addi / j / jr back-to-back; fourth word fills DEPTH
    ctrl(1'b1, 1'b0);
    step(1'b1, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0, 1'b0);
    check("r_add_data", bus.imem_data, 32'h00443000);
    check("r_add_addr", bus.imem_addr, AW'(BASE));
    offer(5'b00101, 5'd5, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    check("addi_data", bus.imem_data, 32'h2941FFFF);
`ifdef ENC_CHECKSUM_EN
    csum_2w = 32'h2905CFFF;
`else
    csum_2w = 32'h0;
`endif
    check("checksum_2w", checksum, csum_2w);
    offer(5'b00001, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100);
    check("j_data", bus.imem_data, 32'h08000100);
    offer(5'b00100, 5'd31, 5'd0, 5'd7, 17'd0, 27'd0);
    check("jr_data", bus.imem_data, 32'h27C00000);
    check("jr_addr", bus.imem_addr, AW'(BASE + 3));
    offer(5'b00101, 5'd1, 5'd1, 5'd1, 17'd1, 27'd0);
    check("fifth_no_we", bus.imem_we, 1'b0);
    ctrl(1'b0, 1'b1);

    // unsupported opcode between two legal words
    ctrl(1'b1, 1'b0);
    offer(5'b00000, 5'd1, 5'd2, 5'd3, 17'd0, 27'd0);
    offer(5'b01111, 5'd4, 5'd4, 5'd4, 17'd4, 27'd4);
    check("illegal_no_we", bus.imem_we, 1'b0);
    offer(5'b00011, 5'd0, 5'd0, 5'd0, 17'd0, 27'h2A);
    check("after_illegal_addr", bus.imem_addr, AW'(BASE + 1));

    // start with in_valid mid-session restarts at BASE
    step(1'b1, 5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h5, 1'b1, 1'b0);
    check("restart_no_we", bus.imem_we, 1'b0);
    offer(5'b00001, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7);
    check("restart_addr", bus.imem_addr, AW'(BASE));

    // reset while a write is being presented
    offer(5'b00111, 5'd3, 5'd4, 5'd0, 17'h123, 27'd0);
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // randomized sessions
    for (int i = 0; i < 400; i++) begin
      st  = (!m_loading && m_count != DEPTH) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      fin = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) < 8) op = 5'(legal_ops[$urandom_range(0, 10)]);
      else                         op = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 17'($urandom), 27'($urandom), st, fin);
    end

    ctrl(1'b0, 1'b0);
    ctrl(1'b0, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
